uart_bus_bridge: RTL

- Host-side command responder behind the buart byte interface. Parses framed read/write commands from the receive side and issues 32-bit PicoRV32-style memory transactions.
- Returns responses through the transmit side.
- Used as a debug/loader port that peeks and pokes SoC memory without CPU involvement.

---
 rtl/uart_bus_bridge_pkg.sv | 28 ++
 rtl/uart_bus_bridge_if.sv | 26 ++
 rtl/uart_bus_bridge_timeout.sv | 37 +++
 rtl/uart_bus_bridge.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_bus_bridge_pkg.sv
// Shared opcodes, response bytes, FSM states and bus request layout for the UART bus bridge.
// Frames are little-endian: 'W' A0..A3 D0..D3 -> 'K', 'R' A0..A3 -> R0..R3.
package uart_bridge_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RESP_ACK = 8'h4B;
  localparam logic [7:0] RESP_ERR = 8'h3F;

  localparam int unsigned ADDR_BYTES  = 4;
  localparam int unsigned DATA_BYTES  = 4;
  localparam int unsigned RDATA_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS,
    ST_SEND
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Byte-stream (buart rx/tx) and PicoRV32-style memory bus seen by the bridge.
// master = bridge side, slave = buart + memory side.
interface uart_bus_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_rd;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  rx_data, rx_valid, tx_busy, mem_rdata, mem_ready,
    output rx_rd, tx_data, tx_wr, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, mem_rdata, mem_ready,
    input  rx_rd, tx_data, tx_wr, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/uart_bus_bridge_timeout.sv
// Inter-byte idle counter: clears on clr or when disabled, expire holds while count == TIMEOUT_CYCLES.
// Latency: expire asserts TIMEOUT_CYCLES cycles after the last clear; no backpressure.
module bridge_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!en || clr) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q == LIMIT);

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command responder: parses R/W frames from buart rx, runs one 32-bit bus access, answers on buart tx.
// Latency: last frame byte consumed -> mem_valid in 2 cycles; waits indefinitely on mem_ready and tx_busy.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter logic [7:0]  CMD_READ       = uart_bridge_pkg::OP_READ,
  parameter logic [7:0]  CMD_WRITE      = uart_bridge_pkg::OP_WRITE
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_bus_bridge_if.master        bus,
  output logic                     active
);

  state_t      state_q, state_d;
  logic [1:0]  bytecnt_q, bytecnt_d;
  logic        is_write_q, is_write_d;
  mem_req_t    req_q, req_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] resp_q, resp_d;
  logic [2:0]  resp_len_q, resp_len_d;
  logic [1:0]  tx_idx_q, tx_idx_d;
  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        holdoff_q, holdoff_d;
  logic        txhold_q, txhold_d;
  logic        active_q, active_d;

  logic accepting;
  logic consume;
  logic expire;
  logic tmo_en;

  assign accepting = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign tmo_en    = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  // A timeout in the same cycle as a new byte wins; the byte stays pending as the next opcode.
  assign consume   = bus.rx_valid && !holdoff_q && accepting && !expire && !reset;

  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .en    (tmo_en),
    .clr   (consume),
    .expire(expire)
  );

  always_comb begin
    state_d     = state_q;
    bytecnt_d   = bytecnt_q;
    is_write_d  = is_write_q;
    req_d       = req_q;
    mem_valid_d = mem_valid_q;
    resp_d      = resp_q;
    resp_len_d  = resp_len_q;
    tx_idx_d    = tx_idx_q;
    tx_wr_d     = 1'b0;
    tx_data_d   = tx_data_q;
    // buart drops rx_valid and raises tx_busy one cycle late; mask those stale cycles.
    holdoff_d   = consume;
    txhold_d    = tx_wr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (consume) begin
          if (bus.rx_data == CMD_READ || bus.rx_data == CMD_WRITE) begin
            is_write_d = (bus.rx_data == CMD_WRITE);
            bytecnt_d  = 2'd0;
            state_d    = ST_GET_ADDR;
          end else begin
            resp_d     = {24'h0, RESP_ERR};
            resp_len_d = 3'd1;
            tx_idx_d   = 2'd0;
            state_d    = ST_SEND;
          end
        end
      end

      ST_GET_ADDR: begin
        if (expire) begin
          state_d = ST_IDLE;
        end else if (consume) begin
          req_d.addr[{bytecnt_q, 3'b000} +: 8] = bus.rx_data;
          bytecnt_d = bytecnt_q + 2'd1;
          if (bytecnt_q == 2'(ADDR_BYTES - 1)) begin
            state_d = is_write_q ? ST_GET_DATA : ST_BUS;
          end
        end
      end

      ST_GET_DATA: begin
        if (expire) begin
          state_d = ST_IDLE;
        end else if (consume) begin
          req_d.wdata[{bytecnt_q, 3'b000} +: 8] = bus.rx_data;
          bytecnt_d = bytecnt_q + 2'd1;
          if (bytecnt_q == 2'(DATA_BYTES - 1)) begin
            state_d = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          req_d.wstrb = is_write_q ? 4'hF : 4'h0;
        end else if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          req_d.wstrb = 4'h0;
          resp_d      = is_write_q ? {24'h0, RESP_ACK} : bus.mem_rdata;
          resp_len_d  = is_write_q ? 3'd1 : 3'(RDATA_BYTES);
          tx_idx_d    = 2'd0;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!bus.tx_busy && !txhold_q && !tx_wr_q) begin
          tx_wr_d   = 1'b1;
          tx_data_d = resp_q[{tx_idx_q, 3'b000} +: 8];
          tx_idx_d  = tx_idx_q + 2'd1;
          if ({1'b0, tx_idx_q} == resp_len_q - 3'd1) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bytecnt_q   <= 2'd0;
      is_write_q  <= 1'b0;
      req_q       <= '0;
      mem_valid_q <= 1'b0;
      resp_q      <= 32'h0;
      resp_len_q  <= 3'd0;
      tx_idx_q    <= 2'd0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= 8'h0;
      holdoff_q   <= 1'b0;
      txhold_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bytecnt_q   <= bytecnt_d;
      is_write_q  <= is_write_d;
      req_q       <= req_d;
      mem_valid_q <= mem_valid_d;
      resp_q      <= resp_d;
      resp_len_q  <= resp_len_d;
      tx_idx_q    <= tx_idx_d;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
      holdoff_q   <= holdoff_d;
      txhold_q    <= txhold_d;
      active_q    <= active_d;
    end
  end

  assign bus.rx_rd     = consume;
  assign bus.tx_wr     = tx_wr_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = {req_q.addr[31:2], 2'b00};
  assign bus.mem_wdata = req_q.wdata;
  assign bus.mem_wstrb = req_q.wstrb;
  assign active        = active_q;

endmodule
